// File: rtl/percept_seq_if.sv
// Operand-pair input and result output handshakes of the perceptron sequencer.
interface percept_seq_if #(
  parameter int unsigned SIZE = 32
);
  localparam int unsigned ACC_W = 4 * SIZE;

  logic             in_valid;
  logic             in_ready;
  logic [SIZE-1:0]  in_a;
  logic [SIZE-1:0]  in_b;
  logic             in_last;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;

  modport master (
    output in_valid, in_a, in_b, in_last, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, res_ready,
    output in_ready, res_valid, res_data
  );
endinterface

// File: rtl/percept_seq.sv
// Sequencer for the serial MAC perceptron stage: serialises operand pairs,
// issues stage command strobes, and deserialises the accumulator on the last pair.
module percept_seq #(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic         clk,
  input  logic         nRst,
  percept_seq_if.slave bus,
  output logic         shift_in,
  output logic         shift_out,
  output logic         mul,
  output logic         acc,
  output logic         data_in,
  input  logic         pe_data,
  output logic         busy
);
  localparam int unsigned ACC_W  = 4 * SIZE;
  localparam int unsigned PAIR_W = 2 * SIZE;

  typedef enum logic [2:0] {
    IDLE, SHIFT, MUL, ACC, DRAIN, CAPT, RESULT
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [PAIR_W-1:0] sreg;
  logic              last_q;

  // Outputs are registered alongside the state so each one is a pure decode
  // of the state being entered.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state         <= IDLE;
      cnt           <= '0;
      sreg          <= '0;
      last_q        <= 1'b0;
      shift_in      <= 1'b0;
      shift_out     <= 1'b0;
      mul           <= 1'b0;
      acc           <= 1'b0;
      data_in       <= 1'b0;
      busy          <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
    end else begin
      shift_in  <= 1'b0;
      shift_out <= 1'b0;
      mul       <= 1'b0;
      acc       <= 1'b0;
      data_in   <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sreg         <= {bus.in_a, bus.in_b};
            last_q       <= bus.in_last;
            cnt          <= '0;
            state        <= SHIFT;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
            shift_in     <= 1'b1;
            data_in      <= bus.in_a[SIZE-1];
          end
        end

        // data_in always carries the MSB of the not-yet-sent remainder.
        SHIFT: begin
          sreg <= {sreg[PAIR_W-2:0], 1'b0};
          if (cnt == CNT_W'(PAIR_W - 1)) begin
            state <= MUL;
            mul   <= 1'b1;
          end else begin
            cnt      <= cnt + CNT_W'(1);
            shift_in <= 1'b1;
            data_in  <= sreg[PAIR_W-2];
          end
        end

        MUL: begin
          state <= ACC;
          acc   <= 1'b1;
        end

        ACC: begin
          if (!last_q) begin
            state        <= IDLE;
            bus.in_ready <= 1'b1;
            busy         <= 1'b0;
          end else begin
            cnt       <= '0;
            state     <= DRAIN;
            shift_out <= 1'b1;
          end
        end

        // pe_data lags shift_out by one cycle, so the first drain cycle has nothing to capture.
        DRAIN: begin
          if (cnt != '0) begin
            bus.res_data <= {bus.res_data[ACC_W-2:0], pe_data};
          end
          if (cnt == CNT_W'(ACC_W - 1)) begin
            state <= CAPT;
          end else begin
            cnt       <= cnt + CNT_W'(1);
            shift_out <= 1'b1;
          end
        end

        CAPT: begin
          bus.res_data  <= {bus.res_data[ACC_W-2:0], pe_data};
          state         <= RESULT;
          bus.res_valid <= 1'b1;
        end

        RESULT: begin
          if (bus.res_ready) begin
            state         <= IDLE;
            bus.res_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
          end
        end

        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.res_valid <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_percept_seq.sv
// Bench for percept_seq: a behavioural serial MAC stage plus an arithmetic dot-product reference.
module tb_percept_seq;
  localparam int unsigned SIZE  = 32;
  localparam int unsigned ACC_W = 4 * SIZE;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic shift_in, shift_out, mul, acc, data_in, busy;
  logic pe_data;

  percept_seq_if #(.SIZE(SIZE)) bus ();

  percept_seq #(.SIZE(SIZE), .CNT_W(8)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .bus       (bus),
    .shift_in  (shift_in),
    .shift_out (shift_out),
    .mul       (mul),
    .acc       (acc),
    .data_in   (data_in),
    .pe_data   (pe_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Serial MAC stage model sharing nRst with the sequencer.
  logic [SIZE-1:0]   d2, d1;
  logic [2*SIZE-1:0] prod;
  logic [ACC_W-1:0]  accum;

  always @(posedge clk) begin
    if (!nRst) begin
      d2 <= '0; d1 <= '0; prod <= '0; accum <= '0; pe_data <= 1'b0;
    end else begin
      if (shift_in)  {d2, d1} <= {d2[SIZE-2:0], d1, data_in};
      if (mul)       prod <= (2*SIZE)'(d2) * (2*SIZE)'(d1);
      if (acc)       accum <= accum + ACC_W'(prod);
      if (shift_out) begin
        pe_data <= accum[ACC_W-1];
        accum   <= {accum[ACC_W-2:0], 1'b0};
      end
    end
  end

  // Strobe counters since the latest acceptance, plus per-cycle rule violations.
  int n_si = 0, n_so = 0, n_mul = 0, n_acc = 0, n_viol = 0;
  logic [2*SIZE-1:0] pat = '0;

  always @(posedge clk) begin
    if (!nRst || (bus.in_valid && bus.in_ready)) begin
      n_si <= 0; n_so <= 0; n_mul <= 0; n_acc <= 0; pat <= '0;
    end else begin
      n_si  <= n_si  + int'(shift_in);
      n_so  <= n_so  + int'(shift_out);
      n_mul <= n_mul + int'(mul);
      n_acc <= n_acc + int'(acc);
      if (shift_in) pat <= {pat[2*SIZE-2:0], data_in};
    end
    if (nRst) begin
      if ((int'(shift_in) + int'(shift_out) + int'(mul) + int'(acc)) > 1) n_viol <= n_viol + 1;
      else if (data_in && !shift_in) n_viol <= n_viol + 1;
      else if (busy === bus.in_ready) n_viol <= n_viol + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [ACC_W-1:0]  exp_sum = '0;
  logic [2*SIZE-1:0] exp_pat = '0;

  task automatic check(input string tag, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, ACC_W'({shift_in, shift_out, mul, acc, data_in, bus.res_valid, busy, bus.in_ready}),
          ACC_W'(8'b0000_0001));
    check({tag, "_res"}, bus.res_data, '0);
  endtask

  task automatic drive_pair(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic last);
    int k = 0;
    while (!bus.in_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_wait", ACC_W'(bus.in_ready), ACC_W'(1'b1));
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_last = last;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    exp_sum = exp_sum + ACC_W'(a) * ACC_W'(b);
    exp_pat = {a, b};
  endtask

  task automatic check_pair_strobes();
    check("shift_in_cnt", ACC_W'(n_si), ACC_W'(64));
    check("mul_cnt", ACC_W'(n_mul), ACC_W'(1));
    check("acc_cnt", ACC_W'(n_acc), ACC_W'(1));
    check("bit_pattern", ACC_W'(pat), ACC_W'(exp_pat));
    check("rules", ACC_W'(n_viol), '0);
  endtask

  task automatic finish_pair();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.in_ready && k < 400);
    check("pair_latency", ACC_W'(k), ACC_W'(67));
    check_pair_strobes();
  endtask

  task automatic finish_last(input int hold, output logic [ACC_W-1:0] r);
    int k = 0;
    int bad = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.res_valid && k < 400);
    check("res_latency", ACC_W'(k), ACC_W'(196));
    check_pair_strobes();
    check("shift_out_cnt", ACC_W'(n_so), ACC_W'(128));
    check("res_data", bus.res_data, exp_sum);
    check("stage_cleared", accum, '0);
    r = bus.res_data;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1; bus.in_a = $urandom; bus.in_b = $urandom; bus.in_last = 1'b1;
      @(negedge clk);
      if (!bus.res_valid || bus.res_data !== r || bus.in_ready || shift_in) bad++;
    end
    bus.in_valid = 1'b0;
    check("hold_stable", ACC_W'(bad), '0);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    @(negedge clk);
    check("back_idle", ACC_W'({bus.res_valid, bus.in_ready, busy}), ACC_W'(3'b010));
    check("res_kept", bus.res_data, r);
    exp_sum = '0;
  endtask

  logic [ACC_W-1:0] r;

  initial begin
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_last = 1'b0; bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    nRst = 1'b1;
    @(negedge clk);

    // Single pair 3*5.
    drive_pair(32'd3, 32'd5, 1'b1);
    finish_last(0, r);
    check("t1_value", r, ACC_W'(15));

    // Three-pair dot product, then a fresh one.
    drive_pair(32'd2, 32'd3, 1'b0); finish_pair();
    drive_pair(32'd4, 32'd5, 1'b0); finish_pair();
    drive_pair(32'd6, 32'd7, 1'b1); finish_last(0, r);
    check("t2_value", r, ACC_W'(68));
    drive_pair(32'd1, 32'd1, 1'b1); finish_last(0, r);
    check("t2_cleared", r, ACC_W'(1));

    // Maximum operands.
    drive_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); finish_last(0, r);
    check("t3_value", r, ACC_W'(64'hFFFF_FFFE_0000_0001));

    // Back-pressure on the result.
    drive_pair(32'd11, 32'd13, 1'b1); finish_last(10, r);
    check("t4_value", r, ACC_W'(143));

    // Reset during SHIFT abandons the partial sum.
    drive_pair(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    repeat (20) @(negedge clk);
    nRst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    exp_sum = '0;
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    drive_pair(32'd7, 32'd9, 1'b1); finish_last(0, r);
    check("t5_value", r, ACC_W'(63));

    // Random dot products against the arithmetic reference.
    for (int i = 0; i < 6; i++) begin
      int n = int'($urandom_range(1, 4));
      for (int j = 0; j < n; j++) begin
        logic [SIZE-1:0] a = (($urandom & 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        logic [SIZE-1:0] b = $urandom;
        drive_pair(a, b, j == n - 1);
        if (j == n - 1) finish_last(int'($urandom_range(0, 5)), r);
        else            finish_pair();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/percept_seq.md
Name: percept_seq

Overview:
Upstream sequencer for the serial multiply-accumulate perceptron stage. It accepts parallel operand pairs (a, b) over a valid/ready handshake and serialises each pair onto the stage's data_in line. It issues the shift_in/mul/acc command strobes for each pair. On the pair flagged last, it drains the stage's 4*SIZE-bit accumulator with shift_out, deserialises data_out into a parallel result, and presents that result over a second valid/ready handshake.

Parameters:
SIZE, 32, operand width; must match the datapath stage.
ACC_W, 4*SIZE, result/accumulator width (derived; not overridden).
CNT_W, 8, bit counter width; must satisfy 2^CNT_W > ACC_W.

Ports:
clk  input  1  clock, all logic on rising edge
nRst  input  1  reset, synchronous, active-low
in_valid  input  1  operand pair valid
in_ready  output  1  sequencer can accept a pair
in_a  input  SIZE  operand a
in_b  input  SIZE  operand b
in_last  input  1  final pair of this dot product
shift_in  output  1  to stage: shift data_in into operand registers
shift_out  output  1  to stage: shift accumulator MSB out to data_out
mul  output  1  to stage: multiply operands
acc  output  1  to stage: add product into accumulator
data_in  output  1  to stage: serial operand bit
pe_data  input  1  from stage data_out (registered in the stage)
res_valid  output  1  result valid
res_ready  input  1  result consumer ready
res_data  output  ACC_W  accumulated dot product
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: clk and nRst are fixed as above; reset is synchronous and active-low. On a clk edge with nRst=0, FSM goes to IDLE and all registers clear. After reset, all outputs are 0 except in_ready=1. The stage shares nRst, so reset mid-operation abandons the partial sum.
- FSM states: IDLE, SHIFT, MUL, ACC, DRAIN, CAPT, RESULT.
- IDLE: in_ready=1. If in_valid=1, latch {in_a, in_b} into a 2*SIZE shift register (a in upper half), latch in_last, clear the counter, and go to SHIFT.
- SHIFT: 2*SIZE cycles. shift_in=1 and data_in=shift register MSB; the register shifts left each cycle. Bit order is a MSB-first, then b MSB-first. After these cycles the stage holds a in data_2 and b in data_1. Then go to MUL.
- MUL: 1 cycle, mul=1, then go to ACC.
- ACC: 1 cycle, acc=1. If the latched last=0, go to IDLE; otherwise clear the counter and go to DRAIN.
- DRAIN: ACC_W cycles with shift_out=1.
  - pe_data lags shift_out by one cycle.
  - In DRAIN cycles 1..ACC_W-1 and in CAPT, res_data <= {res_data[ACC_W-2:0], pe_data}, giving exactly ACC_W captures, MSB first.
  - DRAIN leaves the stage accumulator at zero, ready for the next dot product.
- CAPT: 1 cycle, final capture, then go to RESULT.
- RESULT: res_valid=1 and res_data held stable. Leave to IDLE on the first cycle with res_ready=1. in_ready stays 0 until then.
- Command exclusivity: at most one of shift_in/shift_out/mul/acc is high in any cycle; all four are 0 in IDLE, CAPT and RESULT. data_in=0 outside SHIFT.
- Control outputs are Moore decodes of state. data_in is driven from a register.
- Latency (pair accepted at edge t):
  - shift_in high in cycles t+1..t+2*SIZE
  - mul in t+2*SIZE+1, acc in t+2*SIZE+2
  - non-last pair: in_ready at t+2*SIZE+3
  - last pair: DRAIN t+2*SIZE+3..t+2*SIZE+ACC_W+2, CAPT next cycle, res_valid from t+2*SIZE+ACC_W+4
  - SIZE=32: 67 cycles per pair; res_valid at t+196.
- Arithmetic: the result is the unsigned sum of a*b products, modulo 2^ACC_W. The number of pairs per dot product is unbounded.
- in_valid is ignored while busy. in_a, in_b and in_last are sampled only at acceptance.
- res_data keeps its last value until the next CAPT sequence begins overwriting it.

Test Plan:
1. Reset, then a=3, b=5, last=1 -> 64 shift_in cycles (bit pattern 0x00000003_00000005 MSB-first), mul, acc, 128 shift_out; res_valid at t+196, res_data=15.
2. Pairs (2,3), (4,5), (6,7), last on the third -> in_ready returns 67 cycles after each acceptance; res_data=68; a new pair 1*1 afterwards gives res_data=1, confirming the accumulator was cleared.
3. a=b=0xFFFFFFFF, last=1 -> res_data=0xFFFFFFFE00000001; upper 64 bits 0.
4. Hold res_ready=0 for 10 cycles in RESULT -> res_valid and res_data stable; in_ready=0 with in_valid=1 and no acceptance; res_ready=1 -> IDLE next cycle.
5. Drive nRst=0 during SHIFT cycle 20 -> next edge all outputs 0 except in_ready=1; then 7*9 last -> res_data=63.
6. All runs assert command exclusivity every cycle, and assert that shift_in count=64, mul=1 and acc=1 per pair, and shift_out count=128 per result.
